// File: rtl/pll_mon_pkg.sv
// Shared definitions for the PLL lock supervisor: state codes and status widths.
package pll_mon_pkg;

    localparam int STATE_W = 3;
    localparam int RETRY_W = 4;

    // State codes are visible on the status port, so their values are fixed.
    typedef enum logic [STATE_W-1:0] {
        ST_PWR_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_state_e;

    // Largest of three integers, used to size the shared timer.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/pll_lock_mgr_sync_2ff.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back capture flops; only the second stage is used downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_mgr.sv
// PLL reset/lock supervisor: pulses PLL reset, qualifies LOCK, releases the
// PLL output domain reset and recovers from lock loss or repeated timeouts.
module pll_lock_mgr
    import pll_mon_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int LOSS_FILTER   = 4,
    parameter int MAX_RETRY     = 7,
    parameter int CNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               soft_rst,
    input  logic               pll_lock_in,
    output logic               pll_rst,
    output logic               domain_rst_n,
    output logic               locked_ok,
    output logic               pll_fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [CNT_W-1:0]   loss_cnt,
    output logic [STATE_W-1:0] state
);

    localparam int TMR_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);
    localparam int FLT_W = $clog2(LOSS_FILTER + 1);

    // Terminal timer/filter values: the transition fires on the last counted cycle.
    localparam logic [TMR_W-1:0]   RST_LAST = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0]   TO_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]   STB_LAST = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [FLT_W-1:0]   FLT_LAST = FLT_W'(LOSS_FILTER - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    logic               lock_s;
    pll_state_e         state_q,  state_d;
    logic [TMR_W-1:0]   timer_q,  timer_d;
    logic [FLT_W-1:0]   filt_q,   filt_d;
    logic [RETRY_W-1:0] retry_q,  retry_d;
    logic [CNT_W-1:0]   loss_q,   loss_d;
    logic               pll_rst_q,  pll_rst_d;
    logic               dom_rst_n_q, dom_rst_n_d;
    logic               locked_q, locked_d;
    logic               fail_q,   fail_d;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pll_lock_in),
        .q_o   (lock_s)
    );

    // Next-state, shared timer, loss filter and counter updates.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + TMR_W'(1);
        filt_d  = '0;
        retry_d = retry_q;
        loss_d  = loss_q;
        if (soft_rst) begin
            state_d = ST_PWR_RST;
            timer_d = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_PWR_RST: begin
                    if (timer_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        timer_d = '0;
                    end else begin
                        state_d = ST_PWR_RST;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABLE;
                        timer_d = '0;
                    end else if (timer_q == TO_LAST) begin
                        timer_d = '0;
                        if (retry_q == RETRY_MAX) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_PWR_RST;
                            retry_d = retry_q + RETRY_W'(1);
                        end
                    end else begin
                        state_d = ST_WAIT_LOCK;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        // Lock dropped before qualifying: wait again without charging a retry.
                        state_d = ST_WAIT_LOCK;
                        timer_d = '0;
                    end else if (timer_q == STB_LAST) begin
                        state_d = ST_RUN;
                        timer_d = '0;
                        retry_d = '0;
                    end else begin
                        state_d = ST_STABLE;
                    end
                end
                ST_RUN: begin
                    timer_d = '0;
                    if (lock_s) begin
                        filt_d = '0;
                    end else if (filt_q == FLT_LAST) begin
                        state_d = ST_PWR_RST;
                        filt_d  = '0;
                        if (loss_q != '1) begin
                            loss_d = loss_q + CNT_W'(1);
                        end else begin
                            loss_d = loss_q;
                        end
                    end else begin
                        filt_d = filt_q + FLT_W'(1);
                    end
                end
                ST_FAIL: begin
                    timer_d = '0;
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_PWR_RST;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Output values decoded from the next state so they update with the state register.
    always_comb begin
        pll_rst_d   = 1'b0;
        dom_rst_n_d = 1'b0;
        locked_d    = 1'b0;
        fail_d      = 1'b0;
        case (state_d)
            ST_PWR_RST: begin
                pll_rst_d = 1'b1;
            end
            ST_WAIT_LOCK, ST_STABLE: begin
                pll_rst_d = 1'b0;
            end
            ST_RUN: begin
                dom_rst_n_d = 1'b1;
                locked_d    = 1'b1;
            end
            ST_FAIL: begin
                pll_rst_d = 1'b1;
                fail_d    = 1'b1;
            end
            default: begin
                pll_rst_d = 1'b1;
            end
        endcase
    end

    // State, timer, filter, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_PWR_RST;
            timer_q     <= '0;
            filt_q      <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_rst_q   <= 1'b1;
            dom_rst_n_q <= 1'b0;
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            filt_q      <= filt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_rst_q   <= pll_rst_d;
            dom_rst_n_q <= dom_rst_n_d;
            locked_q    <= locked_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_rst      = pll_rst_q;
    assign domain_rst_n = dom_rst_n_q;
    assign locked_ok    = locked_q;
    assign pll_fail     = fail_q;
    assign retry_cnt    = retry_q;
    assign loss_cnt     = loss_q;
    assign state        = state_q;

endmodule

// File: tb/tb_pll_lock_mgr.sv
// Self-checking bench for pll_lock_mgr: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized lock/soft_rst traffic.
module tb_pll_lock_mgr;

    localparam int P_RST  = 4;
    localparam int P_TO   = 20;
    localparam int P_STB  = 8;
    localparam int P_LF   = 3;
    localparam int P_MAXR = 2;

    logic       clk;
    logic       rst_n;
    logic       soft_rst;
    logic       pll_lock_in;
    logic       pll_rst;
    logic       domain_rst_n;
    logic       locked_ok;
    logic       pll_fail;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic [2:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: phase 0..4 = reset pulse, wait lock, stable, run, fail.
    int m_ph, m_t, m_low, m_retry, m_loss;
    int h0, h1, ls;

    pll_lock_mgr #(
        .RST_CYCLES   (P_RST),
        .LOCK_TIMEOUT (P_TO),
        .STABLE_CYCLES(P_STB),
        .LOSS_FILTER  (P_LF),
        .MAX_RETRY    (P_MAXR),
        .CNT_W        (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .soft_rst     (soft_rst),
        .pll_lock_in  (pll_lock_in),
        .pll_rst      (pll_rst),
        .domain_rst_n (domain_rst_n),
        .locked_ok    (locked_ok),
        .pll_fail     (pll_fail),
        .retry_cnt    (retry_cnt),
        .loss_cnt     (loss_cnt),
        .state        (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model advanced on each clock edge, then every output compared.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph = 0; m_t = 0; m_low = 0; m_retry = 0; m_loss = 0;
            h0 = 0; h1 = 0;
        end else begin
            ls = h1;                  // lock value the supervisor acts on (2 edges old)
            h1 = h0;
            h0 = int'(pll_lock_in);
            if (soft_rst) begin
                m_ph = 0; m_t = 0; m_low = 0; m_retry = 0;
            end else begin
                case (m_ph)
                    0: begin
                        m_t++;
                        if (m_t == P_RST) begin m_ph = 1; m_t = 0; end
                    end
                    1: begin
                        if (ls != 0) begin
                            m_ph = 2; m_t = 0;
                        end else begin
                            m_t++;
                            if (m_t == P_TO) begin
                                m_t = 0;
                                if (m_retry == P_MAXR) m_ph = 4;
                                else begin m_retry++; m_ph = 0; end
                            end
                        end
                    end
                    2: begin
                        if (ls == 0) begin
                            m_ph = 1; m_t = 0;
                        end else begin
                            m_t++;
                            if (m_t == P_STB) begin m_ph = 3; m_t = 0; m_retry = 0; m_low = 0; end
                        end
                    end
                    3: begin
                        if (ls != 0) m_low = 0;
                        else begin
                            m_low++;
                            if (m_low == P_LF) begin
                                m_ph = 0; m_t = 0; m_low = 0;
                                if (m_loss < 255) m_loss++;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
        #1;
        chk("m_state",    int'(state),        m_ph);
        chk("m_pll_rst",  int'(pll_rst),      (m_ph == 0 || m_ph == 4) ? 1 : 0);
        chk("m_domain",   int'(domain_rst_n), (m_ph == 3) ? 1 : 0);
        chk("m_locked",   int'(locked_ok),    (m_ph == 3) ? 1 : 0);
        chk("m_fail",     int'(pll_fail),     (m_ph == 4) ? 1 : 0);
        chk("m_retry",    int'(retry_cnt),    m_retry);
        chk("m_loss",     int'(loss_cnt),     m_loss);
    end

    // Directed scenarios followed by random traffic.
    initial begin
        int cnt, rises, prev, run_left;
        rst_n = 1'b0; soft_rst = 1'b0; pll_lock_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state",  int'(state), 0);
        chk("rst_pllrst", int'(pll_rst), 1);
        chk("rst_domain", int'(domain_rst_n), 0);
        chk("rst_retry",  int'(retry_cnt), 0);
        chk("rst_loss",   int'(loss_cnt), 0);

        // Power-up: count cycles of pll_rst, then lock 10 cycles after release.
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (pll_rst) cnt++;
            @(negedge clk);
        end
        chk("pwr_rst_len", cnt, 4);
        pll_lock_in = 1'b1;
        @(posedge clk);               // edge that first samples the lock rise
        cnt = 0;
        while (!domain_rst_n && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("lock_to_release", cnt, 10);
        chk("pwr_retry", int'(retry_cnt), 0);
        chk("pwr_run_state", int'(state), 3);

        // RUN: 2-cycle glitch ignored, 3-cycle loss restarts.
        @(negedge clk); pll_lock_in = 1'b0;
        repeat (2) @(negedge clk); pll_lock_in = 1'b1;
        repeat (6) @(negedge clk);
        chk("glitch_state",  int'(state), 3);
        chk("glitch_locked", int'(locked_ok), 1);
        chk("glitch_loss",   int'(loss_cnt), 0);
        pll_lock_in = 1'b0;
        cnt = 0;
        while (domain_rst_n && cnt < 10) begin @(negedge clk); cnt++; end
        chk("loss_domain", int'(domain_rst_n), 0);
        chk("loss_state",  int'(state), 0);
        chk("loss_cnt1",   int'(loss_cnt), 1);

        // STABLE: drop mid-qualification, full stable period required again.
        pll_lock_in = 1'b1;
        cnt = 0;
        while (state != 3'd2 && cnt < 40) begin @(negedge clk); cnt++; end
        chk("stb_reach", int'(state), 2);
        repeat (4) @(negedge clk); pll_lock_in = 1'b0;
        @(negedge clk); pll_lock_in = 1'b1;
        cnt = 0;
        while (state != 3'd1 && cnt < 6) begin @(negedge clk); cnt++; end
        chk("stb_drop_state", int'(state), 1);
        chk("stb_drop_retry", int'(retry_cnt), 0);
        cnt = 0;
        while (state != 3'd2 && cnt < 6) begin @(negedge clk); cnt++; end
        cnt = 0;
        while (state != 3'd3 && cnt < 20) begin @(negedge clk); cnt++; end
        chk("stb_rerun_len", cnt, 8);

        // No lock: three reset pulses, then FAIL.
        soft_rst = 1'b1;
        @(negedge clk); soft_rst = 1'b0; pll_lock_in = 1'b0;
        prev = int'(pll_rst); rises = prev; cnt = 0;
        while (!pll_fail && cnt < 300) begin
            @(negedge clk); cnt++;
            if (!pll_fail && pll_rst && prev == 0) rises++;
            prev = int'(pll_rst);
        end
        chk("fail_pulses", rises, 3);
        chk("fail_flag",   int'(pll_fail), 1);
        chk("fail_pllrst", int'(pll_rst), 1);
        chk("fail_retry",  int'(retry_cnt), 2);
        chk("fail_state",  int'(state), 4);

        // Recover from FAIL with soft_rst.
        soft_rst = 1'b1;
        @(negedge clk); soft_rst = 1'b0;
        chk("rec_state", int'(state), 0);
        chk("rec_retry", int'(retry_cnt), 0);
        chk("rec_fail",  int'(pll_fail), 0);
        pll_lock_in = 1'b1;
        cnt = 0;
        while (!locked_ok && cnt < 60) begin @(negedge clk); cnt++; end
        chk("rec_run", int'(locked_ok), 1);

        // soft_rst coincides with the third low cycle: no loss counted.
        @(negedge clk); pll_lock_in = 1'b0;
        repeat (4) @(negedge clk); soft_rst = 1'b1;
        @(negedge clk); soft_rst = 1'b0;
        chk("coinc_state",  int'(state), 0);
        chk("coinc_loss",   int'(loss_cnt), 1);
        chk("coinc_domain", int'(domain_rst_n), 0);

        // Async rst_n in STABLE.
        pll_lock_in = 1'b1;
        cnt = 0;
        while (state != 3'd2 && cnt < 40) begin @(negedge clk); cnt++; end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state",  int'(state), 0);
        chk("arst_pllrst", int'(pll_rst), 1);
        chk("arst_domain", int'(domain_rst_n), 0);
        chk("arst_locked", int'(locked_ok), 0);
        chk("arst_retry",  int'(retry_cnt), 0);
        chk("arst_loss",   int'(loss_cnt), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Random lock behaviour with occasional soft_rst pulses.
        run_left = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            soft_rst = ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0;
            if (run_left == 0) begin
                pll_lock_in = ~pll_lock_in;
                if (pll_lock_in) run_left = $urandom_range(1, 40);
                else if ($urandom_range(0, 9) == 0) run_left = $urandom_range(20, 60);
                else run_left = $urandom_range(1, 5);
            end else begin
                run_left--;
            end
        end
        @(negedge clk);
        soft_rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
